// File: rtl/pulse_avg_ctrl.sv
// Pulse-averaging sequencer: frames input samples into pulses and passes, issuing one
// registered accumulator command per accepted sample. Optional macro PULSE_AVG_CTRL_TLAST_CHECK_EN.
module pulse_avg_ctrl #(
    parameter int MAX_PULSE_SIZE = 8192,
    parameter int ADDR_WIDTH     = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [31:0]           pulse_size,
    input  logic [31:0]           num_avg,
    output logic [31:0]           num_count,
    output logic                  avg_done,
    output logic                  err_tlast,
    input  logic                  i_tvalid,
    input  logic                  i_tlast,
    output logic                  i_tready,
    output logic                  acc_cmd_valid,
    input  logic                  acc_tready,
    output logic [ADDR_WIDTH-1:0] acc_addr,
    output logic                  acc_init,
    output logic                  acc_emit,
    output logic                  acc_last
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state, state_nxt;
    logic                  srst;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] sample_idx;
    logic [31:0]           pass_idx;
    logic [ADDR_WIDTH-1:0] p_last, p_last_cfg;
    logic [31:0]           n_last, n_last_cfg;
    logic                  sample_end;
    logic                  pulse_end;
    logic                  set_end;

    assign srst       = reset | clear;
    assign i_tready   = (state == RUN) && (!acc_cmd_valid || acc_tready);
    assign hs         = i_tvalid & i_tready;
    assign sample_end = (sample_idx == p_last);
    assign set_end    = pulse_end && (pass_idx == n_last);
    assign num_count  = pass_idx;

    // Effective configuration held as last-index values so the counters compare directly.
    always_comb begin
        p_last_cfg = ADDR_WIDTH'(MAX_PULSE_SIZE - 1);
        if (pulse_size != 32'd0 && pulse_size <= 32'(MAX_PULSE_SIZE))
            p_last_cfg = ADDR_WIDTH'(pulse_size - 32'd1);
        n_last_cfg = (num_avg == 32'd0) ? 32'd0 : num_avg - 32'd1;
    end

`ifdef PULSE_AVG_CTRL_TLAST_CHECK_EN
    // An early tlast closes the pulse; a missing one only flags the error.
    assign pulse_end = sample_end | i_tlast;

    always_ff @(posedge clk) begin
        if (srst)
            err_tlast <= 1'b0;
        else if (hs && (i_tlast != sample_end))
            err_tlast <= 1'b1;
    end
`else
    logic unused_tlast;
    assign unused_tlast = i_tlast;
    assign pulse_end    = sample_end;
    assign err_tlast    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (srst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     if (hs && set_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sample_idx    <= '0;
            pass_idx      <= '0;
            p_last        <= '0;
            n_last        <= '0;
            avg_done      <= 1'b0;
            acc_cmd_valid <= 1'b0;
            acc_addr      <= '0;
            acc_init      <= 1'b0;
            acc_emit      <= 1'b0;
            acc_last      <= 1'b0;
        end else begin
            avg_done <= 1'b0;
            if (state == IDLE) begin
                p_last <= p_last_cfg;
                n_last <= n_last_cfg;
            end
            if (hs) begin
                acc_cmd_valid <= 1'b1;
                acc_addr      <= sample_idx;
                acc_init      <= (pass_idx == 32'd0);
                acc_emit      <= (pass_idx == n_last);
                acc_last      <= pulse_end;
                if (pulse_end) begin
                    sample_idx <= '0;
                    if (set_end) begin
                        pass_idx <= '0;
                        avg_done <= 1'b1;
                    end else begin
                        pass_idx <= pass_idx + 32'd1;
                    end
                end else begin
                    sample_idx <= sample_idx + 1'b1;
                end
            end else if (acc_tready) begin
                // Command taken with nothing behind it: empty the slot.
                acc_cmd_valid <= 1'b0;
                acc_addr      <= '0;
                acc_init      <= 1'b0;
                acc_emit      <= 1'b0;
                acc_last      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_avg_ctrl.sv
// Bench for pulse_avg_ctrl: randomized handshakes scored against a sample-count model
// (addr = k mod P, pass = k div P) plus directed scenario checks.
module tb_pulse_avg_ctrl;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset, clear;
    logic [31:0]   pulse_size, num_avg, num_count;
    logic          avg_done, err_tlast, i_tvalid, i_tlast, i_tready;
    logic          acc_cmd_valid, acc_tready, acc_init, acc_emit, acc_last;
    logic [AW-1:0] acc_addr;

    pulse_avg_ctrl #(.MAX_PULSE_SIZE(8192), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .clear(clear), .pulse_size(pulse_size), .num_avg(num_avg),
        .num_count(num_count), .avg_done(avg_done), .err_tlast(err_tlast),
        .i_tvalid(i_tvalid), .i_tlast(i_tlast), .i_tready(i_tready),
        .acc_cmd_valid(acc_cmd_valid), .acc_tready(acc_tready), .acc_addr(acc_addr),
        .acc_init(acc_init), .acc_emit(acc_emit), .acc_last(acc_last)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          init, emit, last;
    } cmd_t;

    cmd_t q[$];
    int   mk = 0, mP = 1, mN = 1;
    bit   done_pend = 0, sb_en = 1;
    int   n_cmd, n_init, n_emit, n_last, n_done;

    function automatic int eff_p(input logic [31:0] ps);
        if (ps == 0 || ps > 8192) return 8192;
        return int'(ps);
    endfunction

    function automatic int eff_n(input logic [31:0] na);
        return (na == 0) ? 1 : int'(na);
    endfunction

    function automatic logic next_tlast();
        int pl;
        pl = (mk == 0) ? eff_p(pulse_size) : mP;
`ifdef PULSE_AVG_CTRL_TLAST_CHECK_EN
        return ((mk % pl) == pl - 1);
`else
        return 1'($urandom_range(1) + 0 * pl);
`endif
    endfunction

    // Scoreboard: the k-th accepted sample of a set maps to addr k%P, pass k/P.
    always @(negedge clk) begin
        if (reset || clear) begin
            q.delete();
            mk = 0;
            done_pend = 0;
        end else if (sb_en) begin
            cmd_t e;
            checks++;
            if (acc_cmd_valid !== (q.size() != 0)) begin
                errors++; $display("FAIL cmd_valid got %0b want %0b", acc_cmd_valid, q.size() != 0);
            end
            checks++;
            if (avg_done !== done_pend) begin
                errors++; $display("FAIL avg_done got %0b want %0b", avg_done, done_pend);
            end
            checks++;
            if (num_count !== 32'(mk / mP)) begin
                errors++; $display("FAIL num_count got %0d want %0d", num_count, mk / mP);
            end
            checks++;
            if (err_tlast !== 1'b0) begin
                errors++; $display("FAIL err_tlast got %0b want 0", err_tlast);
            end
            if (avg_done) n_done++;
            if (acc_cmd_valid && q.size() != 0) begin
                e = q[0];
                checks++;
                if ({acc_addr, acc_init, acc_emit, acc_last} !== {e.addr, e.init, e.emit, e.last}) begin
                    errors++;
                    $display("FAIL cmd got addr=%0d i=%0b e=%0b l=%0b want addr=%0d i=%0b e=%0b l=%0b",
                             acc_addr, acc_init, acc_emit, acc_last, e.addr, e.init, e.emit, e.last);
                end
                if (acc_tready) begin
                    void'(q.pop_front());
                    n_cmd++; n_init += int'(e.init); n_emit += int'(e.emit); n_last += int'(e.last);
                end
            end
            done_pend = 0;
            if (i_tvalid && i_tready) begin
                int pass;
                if (mk == 0) begin
                    mP = eff_p(pulse_size);
                    mN = eff_n(num_avg);
                end
                pass   = mk / mP;
                e.addr = AW'(mk % mP);
                e.init = (pass == 0);
                e.emit = (pass == mN - 1);
                e.last = ((mk % mP) == mP - 1);
                q.push_back(e);
                mk++;
                if (mk == mP * mN) begin
                    mk = 0;
                    done_pend = 1;
                end
            end
        end
    end

    task automatic zero_stats();
        n_cmd = 0; n_init = 0; n_emit = 0; n_last = 0; n_done = 0;
    endtask

    task automatic apply_cfg(input int ps, input int na);
        @(posedge clk); #1;
        pulse_size = ps; num_avg = na; clear = 1; i_tvalid = 0; acc_tready = 1;
        @(posedge clk); #1;
        clear = 0;
        zero_stats();
    endtask

    task automatic stream(input int n, input int vpct, input int rpct);
        int h = 0, cyc = 0;
        while (h < n && cyc < n * 40 + 200) begin
            @(posedge clk); #1;
            i_tvalid   = (int'($urandom_range(99)) < vpct);
            acc_tready = (int'($urandom_range(99)) < rpct);
            i_tlast    = next_tlast();
            @(negedge clk);
            if (i_tvalid && i_tready) h++;
            cyc++;
        end
        checks++;
        if (h < n) begin
            errors++; $display("FAIL stream_timeout got %0d handshakes want %0d", h, n);
        end
        @(posedge clk); #1;
        i_tvalid = 0; acc_tready = 1;
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({acc_cmd_valid, acc_addr, acc_init, acc_emit, acc_last, avg_done, err_tlast, num_count, i_tready} !== '0) begin
            errors++; $display("FAIL reset_values got v=%0b a=%0d n=%0d rdy=%0b want all 0",
                               acc_cmd_valid, acc_addr, num_count, i_tready);
        end
        @(posedge clk); #1; reset = 0;
        @(negedge clk);
        checks++;
        if (i_tready !== 1'b0) begin errors++; $display("FAIL idle_ready got %0b want 0", i_tready); end
        @(negedge clk);
        checks++;
        if (i_tready !== 1'b1) begin errors++; $display("FAIL run_ready got %0b want 1", i_tready); end
    endtask

    task automatic test_basic();
        apply_cfg(4, 3);
        stream(12, 100, 100);
        @(negedge clk);
        checks++;
        if (i_tready !== 1'b0) begin errors++; $display("FAIL basic_dead_cycle got %0b want 0", i_tready); end
        @(negedge clk);
        checks++;
        if (i_tready !== 1'b1) begin errors++; $display("FAIL basic_restart got %0b want 1", i_tready); end
        drain();
        checks++;
        if ({n_cmd, n_init, n_emit, n_last, n_done} !== {32'd12, 32'd4, 32'd4, 32'd3, 32'd1}) begin
            errors++; $display("FAIL basic_counts got cmd=%0d init=%0d emit=%0d last=%0d done=%0d want 12 4 4 3 1",
                               n_cmd, n_init, n_emit, n_last, n_done);
        end
    endtask

    task automatic test_backpressure();
        int h = 0, cyc = 0, stall = 0;
        apply_cfg(4, 3);
        while (h < 12 && cyc < 300) begin
            @(posedge clk); #1;
            i_tvalid = 1; acc_tready = (stall > 0) ? 0 : 1; i_tlast = next_tlast();
            @(negedge clk);
            if (stall > 0) begin
                checks++;
                if ({acc_cmd_valid, acc_addr, i_tready} !== {1'b1, AW'(2), 1'b0}) begin
                    errors++; $display("FAIL bp_hold got v=%0b addr=%0d rdy=%0b want 1 2 0",
                                       acc_cmd_valid, acc_addr, i_tready);
                end
                stall--;
            end
            if (i_tvalid && i_tready) begin
                h++;
                if (h == 3) stall = 3;
            end
            cyc++;
        end
        @(posedge clk); #1; i_tvalid = 0; acc_tready = 1;
        drain();
        checks++;
        if (n_cmd != 12 || n_done != 1) begin
            errors++; $display("FAIL bp_counts got cmd=%0d done=%0d want 12 1", n_cmd, n_done);
        end
    endtask

    task automatic test_clamp_n();
        apply_cfg(2, 0);
        stream(8, 100, 100);
        drain();
        checks++;
        if ({n_cmd, n_init, n_emit, n_last, n_done} !== {32'd8, 32'd8, 32'd8, 32'd4, 32'd4}) begin
            errors++; $display("FAIL clamp_n got cmd=%0d init=%0d emit=%0d last=%0d done=%0d want 8 8 8 4 4",
                               n_cmd, n_init, n_emit, n_last, n_done);
        end
    endtask

    task automatic test_clamp_p();
        apply_cfg(9000, 1);
        stream(8194, 100, 100);
        drain();
        checks++;
        if (n_cmd != 8194 || n_last != 1 || n_done != 1) begin
            errors++; $display("FAIL clamp_p got cmd=%0d last=%0d done=%0d want 8194 1 1", n_cmd, n_last, n_done);
        end
    endtask

    task automatic test_reset_mid();
        apply_cfg(4, 3);
        stream(6, 100, 100);
        reset = 1;
        @(posedge clk); #1; reset = 0;
        zero_stats();
        @(negedge clk);
        checks++;
        if ({acc_cmd_valid, acc_addr, acc_init, acc_emit, acc_last, avg_done, err_tlast, num_count, i_tready} !== '0) begin
            errors++; $display("FAIL mid_reset got v=%0b a=%0d n=%0d rdy=%0b want all 0",
                               acc_cmd_valid, acc_addr, num_count, i_tready);
        end
        stream(1, 100, 100);
        @(negedge clk);
        checks++;
        if ({acc_cmd_valid, acc_addr, acc_init, num_count} !== {1'b1, AW'(0), 1'b1, 32'd0}) begin
            errors++; $display("FAIL restart_first got v=%0b a=%0d init=%0b n=%0d want 1 0 1 0",
                               acc_cmd_valid, acc_addr, acc_init, num_count);
        end
        stream(11, 100, 100);
        drain();
        checks++;
        if (n_cmd != 12 || n_done != 1) begin
            errors++; $display("FAIL restart_counts got cmd=%0d done=%0d want 12 1", n_cmd, n_done);
        end
    endtask

    task automatic test_cfg_change();
        apply_cfg(4, 3);
        stream(6, 100, 100);
        pulse_size = 8;
        stream(30, 100, 100);
        drain();
        checks++;
        if (n_cmd != 36 || n_last != 6 || n_done != 2) begin
            errors++; $display("FAIL cfg_change got cmd=%0d last=%0d done=%0d want 36 6 2", n_cmd, n_last, n_done);
        end
    endtask

`ifdef PULSE_AVG_CTRL_TLAST_CHECK_EN
    task automatic test_tlast();
        logic [AW-1:0] la[4];
        logic          ll[4];
        int h = 0, k = 0;
        apply_cfg(4, 3);
        sb_en = 0;
        repeat (10) begin
            @(posedge clk); #1;
            i_tvalid = (h < 4); i_tlast = (h == 2); acc_tready = 1;
            @(negedge clk);
            if (acc_cmd_valid && k < 4) begin la[k] = acc_addr; ll[k] = acc_last; k++; end
            if (i_tvalid && i_tready) h++;
        end
        checks++;
        if (k != 4 || la[2] !== AW'(2) || ll[2] !== 1'b1 || la[3] !== AW'(0) || err_tlast !== 1'b1 || num_count !== 32'd1) begin
            errors++; $display("FAIL tlast_early got k=%0d a2=%0d l2=%0b a3=%0d err=%0b n=%0d want 4 2 1 0 1 1",
                               k, la[2], ll[2], la[3], err_tlast, num_count);
        end
        apply_cfg(4, 3);
        @(negedge clk);
        checks++;
        if (err_tlast !== 1'b0) begin errors++; $display("FAIL tlast_clear got %0b want 0", err_tlast); end
        sb_en = 1;
    endtask
`endif

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int ps, na, n;
            ps = int'($urandom_range(6, 1));
            na = int'($urandom_range(3, 0));
            n  = int'($urandom_range(60, 10));
            apply_cfg(ps, na);
            stream(n, 70, 60);
            drain();
            checks++;
            if (n_cmd != n || n_done != n / (eff_p(ps) * eff_n(na))) begin
                errors++; $display("FAIL random_%0d got cmd=%0d done=%0d want %0d %0d",
                                   it, n_cmd, n_done, n, n / (eff_p(ps) * eff_n(na)));
            end
        end
    endtask

    initial begin
        reset = 1; clear = 0; pulse_size = 4; num_avg = 3;
        i_tvalid = 0; i_tlast = 0; acc_tready = 1;
        zero_stats();
        test_reset();
        test_basic();
        test_backpressure();
        test_clamp_n();
        test_clamp_p();
        test_reset_mid();
        test_cfg_change();
`ifdef PULSE_AVG_CTRL_TLAST_CHECK_EN
        test_tlast();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
